// File: rtl/ooo_pkg.sv
// rtl/ooo_pkg.sv - shared out-of-order core constants and the CDB packet type
package ooo_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int NUM_PREGS  = 64;
    localparam int PREG_W     = $clog2(NUM_PREGS);
    localparam int ROB_DEPTH  = 16;
    localparam int ROB_W      = $clog2(ROB_DEPTH);
    localparam int NUM_REQ    = 3;

    localparam int REQ_ALU = 0;
    localparam int REQ_BR  = 1;
    localparam int REQ_LSU = 2;

    typedef struct packed {
        logic                  valid;
        logic                  has_rd;
        logic [PREG_W-1:0]     tag;
        logic [DATA_WIDTH-1:0] data;
        logic [ROB_W-1:0]      rob_idx;
    } cdb_pkt_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - generic round-robin arbiter, one-hot grant, pointer moves past each winner
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_grant
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;

    // Walk the requests starting at ptr; the first one seen wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int off = 0; off < N; off++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(off);
            if (sum >= (IDX_W+1)'(N)) begin
                sum = sum - (IDX_W+1)'(N);
            end
            idx = sum[IDX_W-1:0];
            if (enable && !any_grant && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                any_grant  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (any_grant) begin
            ptr <= (grant_idx == IDX_W'(N-1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin CDB/PRF write arbiter; CDB_PERF_EN adds per-requester stall counters
module cdb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PREGS  = 64,
    parameter int PREG_W     = $clog2(NUM_PREGS),
    parameter int ROB_DEPTH  = 16,
    parameter int ROB_W      = $clog2(ROB_DEPTH),
    parameter int NUM_REQ    = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_has_rd,
    input  logic [NUM_REQ*PREG_W-1:0]     req_tag,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*ROB_W-1:0]      req_rob_idx,
    output logic                          cdb_valid,
    output logic [PREG_W-1:0]             cdb_tag,
    output logic [DATA_WIDTH-1:0]         cdb_data,
    output logic [ROB_W-1:0]              cdb_rob_idx,
    output logic [1:0]                    cdb_src,
    output logic                          prf_wen,
    output logic [PREG_W-1:0]             prf_waddr,
    output logic [DATA_WIDTH-1:0]         prf_wdata
`ifdef CDB_PERF_EN
    ,
    output logic [NUM_REQ*32-1:0]         perf_stall_cnt
`endif
);
    import ooo_pkg::cdb_pkt_t;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   win_idx;
    logic               any_grant;
    cdb_pkt_t           win;

    // Holding the arbiter disabled in reset keeps req_ready low while rst_n is asserted.
    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (rst_n & ~flush),
        .req       (req_valid),
        .grant     (grant),
        .grant_idx (win_idx),
        .any_grant (any_grant)
    );

    assign req_ready = grant;

    always_comb begin
        win = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win.valid   = 1'b1;
                win.has_rd  = req_has_rd[i];
                win.tag     = req_tag[i*PREG_W +: PREG_W];
                win.data    = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                win.rob_idx = req_rob_idx[i*ROB_W +: ROB_W];
            end
        end
    end

    // Payload fields only move on a grant so the bus holds its last broadcast when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid   <= 1'b0;
            prf_wen     <= 1'b0;
            cdb_tag     <= '0;
            cdb_data    <= '0;
            cdb_rob_idx <= '0;
            cdb_src     <= '0;
        end else begin
            cdb_valid <= win.valid;
            prf_wen   <= win.valid & win.has_rd & (win.tag != '0);
            if (win.valid) begin
                cdb_tag     <= win.tag;
                cdb_data    <= win.data;
                cdb_rob_idx <= win.rob_idx;
                cdb_src     <= 2'(win_idx);
            end
        end
    end

    assign prf_waddr = cdb_tag;
    assign prf_wdata = cdb_data;

`ifdef CDB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && !req_ready[i] && !flush && perf_stall_cnt[i*32 +: 32] != 32'hFFFF_FFFF) begin
                    perf_stall_cnt[i*32 +: 32] <= perf_stall_cnt[i*32 +: 32] + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter: vector table, directed corners, random vs model
module tb_cdb_arbiter;

    localparam int DW = 32;
    localparam int PW = 6;
    localparam int RW = 4;
    localparam int NR = 3;

    logic           clk;
    logic           rst_n;
    logic           flush;
    logic [NR-1:0]  req_valid;
    logic [NR-1:0]  req_ready;
    logic [NR-1:0]  req_has_rd;
    logic [NR*PW-1:0] req_tag;
    logic [NR*DW-1:0] req_data;
    logic [NR*RW-1:0] req_rob_idx;
    logic           cdb_valid;
    logic [PW-1:0]  cdb_tag;
    logic [DW-1:0]  cdb_data;
    logic [RW-1:0]  cdb_rob_idx;
    logic [1:0]     cdb_src;
    logic           prf_wen;
    logic [PW-1:0]  prf_waddr;
    logic [DW-1:0]  prf_wdata;
`ifdef CDB_PERF_EN
    logic [NR*32-1:0] perf_stall_cnt;
`endif

    cdb_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_has_rd  (req_has_rd),
        .req_tag     (req_tag),
        .req_data    (req_data),
        .req_rob_idx (req_rob_idx),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .cdb_rob_idx (cdb_rob_idx),
        .cdb_src     (cdb_src),
        .prf_wen     (prf_wen),
        .prf_waddr   (prf_waddr),
        .prf_wdata   (prf_wdata)
`ifdef CDB_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  v;
        logic [2:0]  hr;
        logic        fl;
        logic [17:0] tags;
        logic [11:0] robs;
        logic [2:0]  e_rdy;
        logic        e_cv;
        logic [1:0]  e_src;
        logic        e_wen;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] v, input logic [2:0] hr, input logic fl,
                                input logic [17:0] tags, input logic [11:0] robs,
                                input logic [2:0] e_rdy, input logic e_cv,
                                input logic [1:0] e_src, input logic e_wen);
        vec_t t;
        t.v = v; t.hr = hr; t.fl = fl; t.tags = tags; t.robs = robs;
        t.e_rdy = e_rdy; t.e_cv = e_cv; t.e_src = e_src; t.e_wen = e_wen;
        return t;
    endfunction

    task automatic reset_pulse();
        rst_n     = 1'b0;
        req_valid = '0;
        flush     = 1'b0;
        #2;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    vec_t        tbl[17];
    logic [17:0] dt;
    logic [11:0] dr;
    logic [PW-1:0] last_tag;
    logic [DW-1:0] last_data;
    logic [RW-1:0] last_rob;
    logic [1:0]    last_src;

    // random-phase reference state
    int            m_ptr;
    int            m_win;
    int            m_stall[NR];
    int            m_wait[NR];
    bit            pend[NR];
    logic          e_cv, e_wen;
    logic [1:0]    e_src;
    logic [PW-1:0] e_tag;
    logic [DW-1:0] e_data;
    logic [RW-1:0] e_rob;
    logic [2:0]    e_rdy;

    initial begin
        dt = {6'd3, 6'd2, 6'd1};
        dr = {4'd6, 4'd5, 4'd4};
        //             v       hr      fl    tags                  robs                    rdy     cv    src   wen
        tbl[0]  = mk(3'b111, 3'b111, 1'b0, dt,                   dr,                     3'b001, 1'b1, 2'd0, 1'b1);
        tbl[1]  = mk(3'b111, 3'b111, 1'b0, dt,                   dr,                     3'b010, 1'b1, 2'd1, 1'b1);
        tbl[2]  = mk(3'b111, 3'b111, 1'b0, dt,                   dr,                     3'b100, 1'b1, 2'd2, 1'b1);
        tbl[3]  = mk(3'b000, 3'b111, 1'b0, dt,                   dr,                     3'b000, 1'b0, 2'd0, 1'b0);
        tbl[4]  = mk(3'b010, 3'b000, 1'b0, dt,                   {4'd6, 4'd7, 4'd4},     3'b010, 1'b1, 2'd1, 1'b0);
        tbl[5]  = mk(3'b001, 3'b001, 1'b0, {6'd3, 6'd2, 6'd0},   dr,                     3'b001, 1'b1, 2'd0, 1'b0);
        tbl[6]  = mk(3'b111, 3'b111, 1'b1, dt,                   dr,                     3'b000, 1'b0, 2'd0, 1'b0);
        tbl[7]  = mk(3'b111, 3'b111, 1'b0, dt,                   dr,                     3'b010, 1'b1, 2'd1, 1'b1);
        tbl[8]  = mk(3'b100, 3'b111, 1'b0, dt,                   dr,                     3'b100, 1'b1, 2'd2, 1'b1);
        tbl[9]  = mk(3'b100, 3'b111, 1'b0, dt,                   dr,                     3'b100, 1'b1, 2'd2, 1'b1);
        tbl[10] = mk(3'b100, 3'b111, 1'b0, dt,                   dr,                     3'b100, 1'b1, 2'd2, 1'b1);
        tbl[11] = mk(3'b100, 3'b111, 1'b0, dt,                   dr,                     3'b100, 1'b1, 2'd2, 1'b1);
        tbl[12] = mk(3'b101, 3'b111, 1'b0, dt,                   dr,                     3'b001, 1'b1, 2'd0, 1'b1);
        tbl[13] = mk(3'b101, 3'b111, 1'b0, dt,                   dr,                     3'b100, 1'b1, 2'd2, 1'b1);
        tbl[14] = mk(3'b011, 3'b111, 1'b0, dt,                   dr,                     3'b001, 1'b1, 2'd0, 1'b1);
        tbl[15] = mk(3'b011, 3'b111, 1'b0, dt,                   dr,                     3'b010, 1'b1, 2'd1, 1'b1);
        tbl[16] = mk(3'b011, 3'b111, 1'b0, dt,                   dr,                     3'b001, 1'b1, 2'd0, 1'b1);

        // Reset held with every requester valid.
        rst_n       = 1'b0;
        flush       = 1'b0;
        req_valid   = 3'b111;
        req_has_rd  = 3'b111;
        req_tag     = {6'd3, 6'd2, 6'd5};
        req_data    = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF};
        req_rob_idx = dr;
        @(negedge clk);
        check("reset_ready", 64'(req_ready), 64'd0);
        check("reset_cdb_valid", 64'(cdb_valid), 64'd0);
        check("reset_prf_wen", 64'(prf_wen), 64'd0);
        check("reset_cdb_data", 64'(cdb_data), 64'd0);
        rst_n = 1'b1;
        #1;
        check("release_ready", 64'(req_ready), 64'b001);
        @(posedge clk);
        @(negedge clk);
        check("release_cdb_valid", 64'(cdb_valid), 64'd1);
        check("release_src", 64'(cdb_src), 64'd0);
        check("release_prf_wen", 64'(prf_wen), 64'd1);
        check("release_waddr", 64'(prf_waddr), 64'd5);
        check("release_wdata", 64'(prf_wdata), 64'hDEAD_BEEF);

        // Table of single-cycle vectors from a fresh pointer.
        reset_pulse();
        check("pulse_cdb_valid", 64'(cdb_valid), 64'd0);
        last_tag = '0; last_data = '0; last_rob = '0; last_src = '0;
        for (int k = 0; k < 17; k++) begin
            req_valid   = tbl[k].v;
            req_has_rd  = tbl[k].hr;
            flush       = tbl[k].fl;
            req_tag     = tbl[k].tags;
            req_rob_idx = tbl[k].robs;
            for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = {16'(k), 16'(i)};
            #1;
            check($sformatf("tbl%0d_ready", k), 64'(req_ready), 64'(tbl[k].e_rdy));
            if (tbl[k].e_cv) begin
                last_src  = tbl[k].e_src;
                last_data = {16'(k), 16'(tbl[k].e_src)};
                dt        = tbl[k].tags;
                dr        = tbl[k].robs;
                last_tag  = dt[int'(last_src)*PW +: PW];
                last_rob  = dr[int'(last_src)*RW +: RW];
            end
            @(posedge clk);
            @(negedge clk);
            flush = 1'b0;
            check($sformatf("tbl%0d_cdb_valid", k), 64'(cdb_valid), 64'(tbl[k].e_cv));
            check($sformatf("tbl%0d_prf_wen", k), 64'(prf_wen), 64'(tbl[k].e_wen));
            check($sformatf("tbl%0d_src", k), 64'(cdb_src), 64'(last_src));
            check($sformatf("tbl%0d_data", k), 64'(cdb_data), 64'(last_data));
            check($sformatf("tbl%0d_tag", k), 64'(cdb_tag), 64'(last_tag));
            check($sformatf("tbl%0d_rob", k), 64'(cdb_rob_idx), 64'(last_rob));
            check($sformatf("tbl%0d_wdata", k), 64'(prf_wdata), 64'(last_data));
        end

        // ALU and LSU contending from pointer 0: strict alternation, two stalls each.
        reset_pulse();
        req_has_rd = 3'b111;
        req_tag    = {6'd3, 6'd2, 6'd1};
        for (int c = 0; c < 4; c++) begin
            req_valid = 3'b101;
            #1;
            check($sformatf("alt%0d_ready", c), 64'(req_ready), (c % 2 == 0) ? 64'b001 : 64'b100);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("alt%0d_src", c), 64'(cdb_src), (c % 2 == 0) ? 64'd0 : 64'd2);
        end
`ifdef CDB_PERF_EN
        check("perf_alu", 64'(perf_stall_cnt[31:0]), 64'd2);
        check("perf_br", 64'(perf_stall_cnt[63:32]), 64'd0);
        check("perf_lsu", 64'(perf_stall_cnt[95:64]), 64'd2);
`endif

        // Random traffic against a rule-level model; losers hold their payload.
        reset_pulse();
        m_ptr = 0;
        e_cv = 1'b0; e_wen = 1'b0; e_src = '0; e_tag = '0; e_data = '0; e_rob = '0;
        for (int i = 0; i < NR; i++) begin
            m_stall[i] = 0; m_wait[i] = 0; pend[i] = 1'b0;
        end
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i]) begin
                    req_valid[i]            = ($urandom_range(0, 99) < 60);
                    req_has_rd[i]           = ($urandom_range(0, 3) != 0);
                    req_tag[i*PW +: PW]     = PW'($urandom_range(0, 63));
                    req_data[i*DW +: DW]    = $urandom;
                    req_rob_idx[i*RW +: RW] = RW'($urandom_range(0, 15));
                end
            end
            flush = ($urandom_range(0, 15) == 0);
            #1;
            m_win = -1;
            if (!flush) begin
                for (int o = 0; o < NR; o++) begin
                    if (m_win < 0 && req_valid[(m_ptr + o) % NR]) m_win = (m_ptr + o) % NR;
                end
            end
            e_rdy = (m_win >= 0) ? 3'(1 << m_win) : 3'b000;
            check($sformatf("rnd%0d_ready", c), 64'(req_ready), 64'(e_rdy));
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && i != m_win && !flush) begin
                    m_stall[i]++;
                    m_wait[i]++;
                end
            end
            e_cv  = (m_win >= 0);
            e_wen = 1'b0;
            if (m_win >= 0) begin
                check($sformatf("rnd%0d_fair", c), 64'(m_wait[m_win] <= NR - 1), 64'd1);
                m_wait[m_win] = 0;
                e_src  = 2'(m_win);
                e_tag  = req_tag[m_win*PW +: PW];
                e_data = req_data[m_win*DW +: DW];
                e_rob  = req_rob_idx[m_win*RW +: RW];
                e_wen  = req_has_rd[m_win] && (e_tag != 0);
                m_ptr  = (m_win + 1) % NR;
            end
            for (int i = 0; i < NR; i++) pend[i] = req_valid[i] && (i != m_win);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("rnd%0d_cdb", c),
                  {24'd0, cdb_valid, prf_wen, cdb_src, cdb_tag, cdb_rob_idx, cdb_data},
                  {24'd0, e_cv, e_wen, e_src, e_tag, e_rob, e_data});
            check($sformatf("rnd%0d_prf", c), {26'd0, prf_waddr, prf_wdata}, {26'd0, e_tag, e_data});
        end
`ifdef CDB_PERF_EN
        for (int i = 0; i < NR; i++) begin
            check($sformatf("rnd_perf%0d", i), 64'(perf_stall_cnt[i*32 +: 32]), 64'(m_stall[i]));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates the single common data bus (CDB) among the ALU, branch and LSU completion sources.
- Drives the physical register file write port (wen/waddr/wdata) plus the CDB broadcast consumed by the ROB and reservation stations.
- Uses round-robin priority, one grant per cycle, and a registered output stage.
- Losing requesters hold their result under a valid/ready handshake.

Parameters:
- DATA_WIDTH, 32, result width; matches the physical register file.
- NUM_PREGS, 64, physical register count (N_PHYS).
- PREG_W, $clog2(NUM_PREGS), physical tag width.
- ROB_DEPTH, 16, ROB entries.
- ROB_W, $clog2(ROB_DEPTH), ROB index width.
- NUM_REQ, 3, requester count; index 0=ALU, 1=BR, 2=LSU.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  pipeline squash (mispredict/exception).
- req_valid  in  NUM_REQ  requester i has a result.
- req_ready  out  NUM_REQ  requester i granted this cycle.
- req_has_rd  in  NUM_REQ  result writes a destination register.
- req_tag  in  NUM_REQ*PREG_W  destination physical register, packed, requester i at [i*PREG_W +: PREG_W].
- req_data  in  NUM_REQ*DATA_WIDTH  result value, packed.
- req_rob_idx  in  NUM_REQ*ROB_W  ROB entry, packed.
- cdb_valid  out  1  broadcast valid.
- cdb_tag  out  PREG_W  broadcast tag.
- cdb_data  out  DATA_WIDTH  broadcast value.
- cdb_rob_idx  out  ROB_W  completing ROB entry.
- cdb_src  out  2  winning requester index.
- prf_wen  out  1  PRF write enable.
- prf_waddr  out  PREG_W  PRF write address.
- prf_wdata  out  DATA_WIDTH  PRF write data.

Behaviour:
- Reset (rst_n low, async): cdb_valid=0, prf_wen=0, cdb_tag/cdb_data/cdb_rob_idx/cdb_src/prf_waddr/prf_wdata=0, rr_ptr=0. req_ready=0 while reset is asserted.
- Grant (combinational): search req_valid starting at rr_ptr, wrapping modulo NUM_REQ. The first set index wins; req_ready is one-hot on the winner, all-zero if none valid.
- Handshake: a transfer occurs when req_valid[i] & req_ready[i]. req_ready never depends on any requester's ready.
- A requester must hold valid/tag/data/rob_idx stable until it is granted.
- Latency: one cycle. A grant in cycle N produces cdb_valid and prf_wen in cycle N+1.
- Output register: loaded every cycle with the winner's fields. cdb_valid <= |grant.
- prf_wen <= |grant & has_rd & (tag != 0).
- prf_waddr/prf_wdata mirror cdb_tag/cdb_data.
- cdb_tag/cdb_data/cdb_rob_idx/cdb_src hold their last value when cdb_valid=0.
- Pointer: on a grant to i, rr_ptr <= (i+1) mod NUM_REQ; with no grant, rr_ptr holds.
- Fairness: continuously valid requesters are served within NUM_REQ cycles.
- Destination-less results (branch/store without rd) still broadcast with cdb_valid=1 for ROB completion, but prf_wen=0. Tag 0 never asserts prf_wen.
- Flush: req_ready forced to 0 during the flush cycle. Next cycle cdb_valid=0 and prf_wen=0; rr_ptr holds.
- Flush taking effect in cycle N+1 does not retract a broadcast already registered in cycle N.
- Simultaneous: all three valid with rr_ptr=1 grants BR; rr_ptr becomes 2.
- Single requester: valid every cycle, granted every cycle, full throughput.

Optional Feature:
- Macro CDB_PERF_EN.
- Defined: adds output perf_stall_cnt (NUM_REQ*32). Per requester, a 32-bit counter increments each cycle req_valid & ~req_ready & ~flush. Counters reset to 0 on rst_n, saturate at all-ones, and are not cleared by flush.
- Undefined: port and counters absent; behaviour otherwise identical.

Decomposition:
- Package ooo_pkg: NUM_PREGS, PREG_W, ROB_DEPTH, ROB_W, and requester index constants REQ_ALU=0, REQ_BR=1, REQ_LSU=2.
- Package typedef cdb_pkt_t: struct {valid, has_rd, tag, data, rob_idx}.
- Sub-module rr_arbiter (generic NUM_REQ, one-hot grant, pointer update), reusable for issue-port selection.

Test Plan:
- Reset: hold rst_n=0 with all req_valid=1 -> req_ready=000, cdb_valid=0, prf_wen=0. Release -> ALU (tag 5, data 0xDEAD_BEEF) broadcast one cycle later; prf_waddr=5, prf_wdata=0xDEADBEEF.
- Round-robin: ALU/BR/LSU all valid and held for 3 cycles -> grants ALU, BR, LSU in order; cdb_src 0,1,2. Each requester's data appears exactly once, no starvation.
- No destination / tag 0: BR with has_rd=0, rob_idx 7 -> cdb_valid=1, cdb_rob_idx=7, prf_wen=0. ALU tag 0 with has_rd=1 -> prf_wen=0.
- Back-to-back single source: LSU valid 4 cycles with data 1,2,3,4 -> cdb_data 1,2,3,4 on consecutive cycles.
- Flush: all valid, flush=1 for one cycle -> req_ready=000 that cycle, cdb_valid=0 next cycle, rr_ptr unchanged. The following cycle resumes from the same rr_ptr.
- CDB_PERF_EN: ALU and LSU valid 4 cycles with rr_ptr=0 -> grants ALU, LSU, ALU, LSU; each perf_stall_cnt ends at 2.
